// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : I/D two-port arbiter and sequencer for a shared
//                    single-port memory, with bounded fetch starvation.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  // fetch port (read-only)
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  // data port (read/write)
  input  logic          d_req,
  input  logic          d_wen,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  // memory side
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
);

  localparam int            CW      = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t        state_q,     state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          owner_q,     owner_d;      // 1 = D-port owns the access
  logic [AW-1:0] addr_q,      addr_d;
  logic [DW-1:0] wdata_q,     wdata_d;
  logic          wen_q,       wen_d;
  logic          i_gnt_q,     i_gnt_d;
  logic          i_ack_q,     i_ack_d;
  logic          d_gnt_q,     d_gnt_d;
  logic          d_ack_q,     d_ack_d;
  logic [DW-1:0] i_rdata_q,   i_rdata_d;
  logic [DW-1:0] d_rdata_q,   d_rdata_d;

  logic          w_i_wins;

  // I wins when uncontested, or when it has already lost STARVE_LIMIT times in a row
  assign w_i_wins = i_req && (!d_req || (starve_cnt_q == C_LIMIT));

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wen_d        = wen_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_gnt_d      = 1'b0;
    i_ack_d      = 1'b0;
    d_gnt_d      = 1'b0;
    d_ack_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_i_wins) begin
          state_d      = ST_ACCESS;
          owner_d      = 1'b0;
          addr_d       = i_addr;
          wen_d        = 1'b0;
          wdata_d      = '0;
          starve_cnt_d = '0;
          i_gnt_d      = 1'b1;
        end else if (d_req) begin
          state_d = ST_ACCESS;
          owner_d = 1'b1;
          addr_d  = d_addr;
          wen_d   = d_wen;
          wdata_d = d_wdata;
          d_gnt_d = 1'b1;
          if (i_req && (starve_cnt_q != C_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end
      end

      ST_ACCESS: begin
        state_d = ST_IDLE;
        if (owner_q) begin
          d_ack_d = 1'b1;
          if (!wen_q) begin
            d_rdata_d = mem_dout;
          end
        end else begin
          i_ack_d   = 1'b1;
          i_rdata_d = mem_dout;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wen_q        <= 1'b0;
      i_gnt_q      <= 1'b0;
      i_ack_q      <= 1'b0;
      d_gnt_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wen_q        <= wen_d;
      i_gnt_q      <= i_gnt_d;
      i_ack_q      <= i_ack_d;
      d_gnt_q      <= d_gnt_d;
      d_ack_q      <= d_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign busy     = (state_q == ST_ACCESS);
  assign i_gnt    = i_gnt_q;
  assign i_ack    = i_ack_q;
  assign d_gnt    = d_gnt_q;
  assign d_ack    = d_ack_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign mem_addr = busy ? addr_q  : '0;
  assign mem_din  = busy ? wdata_q : '0;
  // rst_n gate keeps a reset asserted mid-store from committing the write
  assign mem_wen  = busy && owner_q && wen_q && rst_n;

endmodule

`default_nettype wire
